// File: rtl/div_datapath.sv
// Datapath for an 8-bit unsigned repeated-subtraction divider.
// An external controller sequences the loads and subtraction steps; PgtN tells it when to stop.
module div_datapath (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] Data_in,
    input  logic       loadN,
    input  logic       loadP,
    input  logic       loadS,
    input  logic       clear,
    input  logic       incQ,
    input  logic       stop,
    output logic       PgtN,
    output logic [7:0] Res,
    output logic [7:0] Rem
);

    logic [7:0] n_q, n_d;
    logic [7:0] p_q, p_d;
    logic [7:0] s_q, s_d;
    logic [7:0] q_q, q_d;
    logic [7:0] res_q, res_d;
    logic [7:0] rem_q, rem_d;

    // A zero divisor also reads as "too big", so divide-by-zero never steps.
    logic p_gt_n;
    assign p_gt_n = (p_q > s_q) || (p_q == 8'd0);

    always_comb begin
        n_d   = n_q;
        p_d   = p_q;
        s_d   = s_q;
        q_d   = q_q;
        res_d = res_q;
        rem_d = rem_q;

        if (clear) begin
            n_d   = 8'd0;
            p_d   = 8'd0;
            s_d   = 8'd0;
            q_d   = 8'd0;
            res_d = 8'd0;
            rem_d = 8'd0;
        end else begin
            if (loadN) n_d = Data_in;
            if (loadP) p_d = Data_in;

            if (loadS) begin
                s_d = n_q;
                q_d = 8'd0;
            end else if (incQ && !p_gt_n) begin
                s_d = s_q - p_q;
                q_d = q_q + 8'd1;
            end

            // Captures pre-edge S/Q, so a coincident step is not included.
            if (stop) begin
                res_d = q_q;
                rem_d = s_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q   <= 8'd0;
            p_q   <= 8'd0;
            s_q   <= 8'd0;
            q_q   <= 8'd0;
            res_q <= 8'd0;
            rem_q <= 8'd0;
        end else begin
            n_q   <= n_d;
            p_q   <= p_d;
            s_q   <= s_d;
            q_q   <= q_d;
            res_q <= res_d;
            rem_q <= rem_d;
        end
    end

    assign PgtN = p_gt_n;
    assign Res  = res_q;
    assign Rem  = rem_q;

endmodule

// File: tb/tb_div_datapath.sv
// Self-checking bench for div_datapath: table-driven divisions plus hand-written
// priority/clear/reset sequences, with a scoreboard queue for stop results.
module tb_div_datapath;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] Data_in;
    logic       loadN, loadP, loadS, clear, incQ, stop;
    logic       PgtN;
    logic [7:0] Res, Rem;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [7:0] res;
        logic [7:0] rem;
        string      name;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string      name;
        logic [7:0] n;
        logic [7:0] p;
        logic       pg_start;
        int         steps;
        logic       pg_end;
        logic [7:0] res;
        logic [7:0] rem;
    } vec_t;
    vec_t vecs[8];

    div_datapath dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Data_in(Data_in),
        .loadN  (loadN),
        .loadP  (loadP),
        .loadS  (loadS),
        .clear  (clear),
        .incQ   (incQ),
        .stop   (stop),
        .PgtN   (PgtN),
        .Res    (Res),
        .Rem    (Rem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; loadN = 1'b0; loadP = 1'b0; loadS = 1'b0;
        clear = 1'b0; incQ = 1'b0; stop = 1'b0;
    endtask

    // Apply whatever controls are currently set for one edge, then release them.
    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic load_operands(input logic [7:0] n, input logic [7:0] p);
        Data_in = n; loadN = 1'b1; tick();
        Data_in = p; loadP = 1'b1; tick();
    endtask

    task automatic push_stop(input string name, input logic [7:0] res, input logic [7:0] rem);
        sb_t e;
        e.res = res; e.rem = rem; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        sb_t e;
        if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard: empty queue at stop, expected one entry");
        end else begin
            e = sb_q.pop_front();
            chk({e.name, " Res"}, Res, e.res);
            chk({e.name, " Rem"}, Rem, e.rem);
        end
    endtask

    task automatic do_stop(input string name, input logic [7:0] res, input logic [7:0] rem);
        push_stop(name, res, rem);
        stop = 1'b1;
        tick();
        pop_check();
    endtask

    initial begin
        vecs[0] = '{"16/3",      8'd16,  8'd3,  1'b0, 5,   1'b1, 8'd5,   8'd1};
        vecs[1] = '{"16/3 x7",   8'd16,  8'd3,  1'b0, 7,   1'b1, 8'd5,   8'd1};
        vecs[2] = '{"16/3 early",8'd16,  8'd3,  1'b0, 4,   1'b0, 8'd4,   8'd4};
        vecs[3] = '{"7/7",       8'd7,   8'd7,  1'b0, 1,   1'b1, 8'd1,   8'd0};
        vecs[4] = '{"5/9",       8'd5,   8'd9,  1'b1, 2,   1'b1, 8'd0,   8'd5};
        vecs[5] = '{"200/0",     8'd200, 8'd0,  1'b1, 3,   1'b1, 8'd0,   8'd200};
        vecs[6] = '{"255/1",     8'd255, 8'd1,  1'b0, 255, 1'b1, 8'd255, 8'd0};
        vecs[7] = '{"100/10 x12",8'd100, 8'd10, 1'b0, 12,  1'b1, 8'd10,  8'd0};

        Data_in = 8'd0;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        chk("reset Res", Res, 8'd0);
        chk("reset Rem", Rem, 8'd0);
        chk("reset PgtN", {7'd0, PgtN}, 8'd1);

        for (int i = 0; i < 8; i++) begin
            load_operands(vecs[i].n, vecs[i].p);
            loadS = 1'b1; tick();
            chk({vecs[i].name, " PgtN start"}, {7'd0, PgtN}, {7'd0, vecs[i].pg_start});
            for (int k = 0; k < vecs[i].steps; k++) begin
                incQ = 1'b1; tick();
            end
            chk({vecs[i].name, " PgtN end"}, {7'd0, PgtN}, {7'd0, vecs[i].pg_end});
            do_stop(vecs[i].name, vecs[i].res, vecs[i].rem);
        end

        // Res/Rem hold across loads, loadS and incQ (last result 10/0).
        load_operands(8'd30, 8'd4);
        loadS = 1'b1; tick();
        incQ = 1'b1; tick();
        chk("hold Res", Res, 8'd10);
        chk("hold Rem", Rem, 8'd0);

        // loadN and loadP together: 50/50, PgtN=0 on equality.
        Data_in = 8'd50; loadN = 1'b1; loadP = 1'b1; tick();
        loadS = 1'b1; tick();
        chk("50/50 PgtN equal", {7'd0, PgtN}, 8'd0);
        incQ = 1'b1; tick();
        chk("50/50 PgtN after", {7'd0, PgtN}, 8'd1);
        do_stop("50/50", 8'd1, 8'd0);

        // loadS beats incQ in the same edge.
        load_operands(8'd16, 8'd3);
        loadS = 1'b1; tick();
        incQ = 1'b1; tick();
        incQ = 1'b1; tick();
        loadS = 1'b1; incQ = 1'b1; tick();
        do_stop("loadS+incQ", 8'd0, 8'd16);

        // stop with incQ captures pre-step values; the step still happens.
        incQ = 1'b1; tick();
        incQ = 1'b1; tick();
        push_stop("stop+incQ", 8'd2, 8'd10);
        stop = 1'b1; incQ = 1'b1; tick();
        pop_check();
        do_stop("after stop+incQ", 8'd3, 8'd7);

        // clear mid-operation zeroes everything, including Res/Rem and P.
        loadS = 1'b1; tick();
        incQ = 1'b1; tick();
        do_stop("pre-clear", 8'd1, 8'd13);
        clear = 1'b1; incQ = 1'b1; stop = 1'b1; loadN = 1'b1; Data_in = 8'd77; tick();
        chk("clear Res", Res, 8'd0);
        chk("clear Rem", Rem, 8'd0);
        chk("clear PgtN", {7'd0, PgtN}, 8'd1);
        loadS = 1'b1; tick();
        do_stop("after clear N", 8'd0, 8'd0);

        // rst_n low mid-operation overrides every control.
        load_operands(8'd16, 8'd3);
        loadS = 1'b1; tick();
        incQ = 1'b1; tick();
        do_stop("pre-reset", 8'd1, 8'd13);
        rst_n = 1'b0; incQ = 1'b1; stop = 1'b1; loadP = 1'b1; Data_in = 8'd9; tick();
        chk("reset mid Res", Res, 8'd0);
        chk("reset mid Rem", Rem, 8'd0);
        chk("reset mid PgtN", {7'd0, PgtN}, 8'd1);

        if (sb_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
